// File: rtl/uart_tx_fifo_engine.sv
// uart_tx_fifo_engine: FIFO-buffered 8N1 UART transmitter; define UART_TX_PARITY_EN to add an even-parity bit
module uart_tx_fifo_engine #(
   parameter int CLK_RATE   = 100000000,
   parameter int BAUD_RATE  = 9600,
   parameter int FIFO_DEPTH = 16,
   localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          tx_valid_i,
   input  logic [7:0]    tx_data_i,
   output logic          tx_ready_o,
   output logic          uart_o,
   output logic          busy_o,
   output logic [LW-1:0] fifo_level_o,
   output logic          frame_done_o
);
   localparam int DIV = CLK_RATE / BAUD_RATE;
   localparam int CW  = $clog2(DIV);
   localparam int AW  = $clog2(FIFO_DEPTH);
`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   logic par;
`else
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
   state_t state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [2:0] idx, idx_n;
   logic [7:0] sh, sh_n;
   logic line_n;
   logic [7:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [LW-1:0] level;
   logic push, pop, bit_end;
   assign bit_end      = cnt == CW'(DIV - 1);
   assign tx_ready_o   = level != LW'(FIFO_DEPTH);
   assign push         = tx_valid_i & tx_ready_o;
   assign fifo_level_o = level;
   assign busy_o       = (state != IDLE) || (level != '0);
   assign frame_done_o = (state == STOP) && bit_end;
   // next-state, shifter and line value; a pop loads the head byte and starts the start bit
   always_comb begin
      pop     = 1'b0;
      state_n = state;
      cnt_n   = bit_end ? '0 : cnt + 1'b1;
      idx_n   = idx;
      sh_n    = sh;
      line_n  = uart_o;
      case (state)
         IDLE: begin
            cnt_n = '0;
            if (level != '0) begin
               pop     = 1'b1;
               state_n = START;
               sh_n    = mem[rd_ptr];
               line_n  = 1'b0;
            end
         end
         START:
            if (bit_end) begin
               state_n = DATA;
               idx_n   = '0;
               line_n  = sh[0];
            end
         DATA:
            if (bit_end) begin
               sh_n  = sh >> 1;
               idx_n = idx + 1'b1;
               if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_n = PARITY;
                  line_n  = par;
`else
                  state_n = STOP;
                  line_n  = 1'b1;
`endif
               end else line_n = sh[1];
            end
`ifdef UART_TX_PARITY_EN
         PARITY:
            if (bit_end) begin
               state_n = STOP;
               line_n  = 1'b1;
            end
`endif
         STOP:
            if (bit_end) begin
               if (level != '0) begin
                  pop     = 1'b1;
                  state_n = START;
                  sh_n    = mem[rd_ptr];
                  line_n  = 1'b0;
               end else state_n = IDLE;
            end
         default: state_n = IDLE;
      endcase
   end
   // FSM, bit timing, shifter, registered line and FIFO bookkeeping
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state  <= IDLE;
         cnt    <= '0;
         idx    <= '0;
         sh     <= '0;
         uart_o <= 1'b1;
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         idx    <= idx_n;
         sh     <= sh_n;
         uart_o <= line_n;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         level <= level + LW'(push) - LW'(pop);
      end
   end
   // FIFO storage, written on the push edge only
   always_ff @(posedge clk_i)
      if (push) mem[wr_ptr] <= tx_data_i;
`ifdef UART_TX_PARITY_EN
   // even parity of the byte entering the shifter
   always_ff @(posedge clk_i or negedge rst_i)
      if (!rst_i) par <= 1'b0;
      else if (pop) par <= ^mem[rd_ptr];
`endif
endmodule
